// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: owns the fetch PC, issues one word
// request at a time to instruction memory, buffers returned words with their
// PC+4 in a small FIFO and presents the head to decode.
// Optional build macro IFQ_BYPASS_EN: forwards an ack straight to the
// outputs when the FIFO is empty (zero-cycle latency).
module if_prefetch_queue #(
    parameter int DEPTH       = 4,
    parameter int ENTRY_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   INT,
    input  logic [31:0]            entryPoint,
    input  logic                   redirect,
    input  logic [31:0]            redirectPC,
    output logic                   imemReq,
    output logic [31:0]            imemAddr,
    input  logic                   imemAck,
    input  logic [ENTRY_WIDTH-1:0] imemData,
    output logic                   insValid,
    output logic [ENTRY_WIDTH-1:0] ins,
    output logic [31:0]            PCp4,
    input  logic                   insReady
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] DEPTH_CNT = DEPTH[PW:0];

    typedef enum logic [1:0] {IDLE, BUSY, SQUASH} reqState_t;

    reqState_t               reqState;
    logic [31:0]             fetchPC;
    logic [ENTRY_WIDTH-1:0]  memIns [DEPTH];
    logic [31:0]             memPc  [DEPTH];
    logic [PW-1:0]           rdPtr, wrPtr, rdPtrNext;
    logic [PW:0]             count, countAfterPop, countNext;
    logic                    insValidQ;
    logic [ENTRY_WIDTH-1:0]  insQ, headIns;
    logic [31:0]             pcp4Q, headPc, pushPc;
    logic                    ackTaken, push, pop, bypassHit;
    logic                    unusedLowBits;

    assign unusedLowBits = ^{entryPoint[1:0], redirectPC[1:0]};

`ifdef IFQ_BYPASS_EN
    assign bypassHit = ackTaken && !redirect && !INT && (count == '0);
    assign insValid  = insValidQ | bypassHit;
    assign ins       = bypassHit ? imemData : insQ;
    assign PCp4      = bypassHit ? pushPc   : pcp4Q;
`else
    assign bypassHit = 1'b0;
    assign insValid  = insValidQ;
    assign ins       = insQ;
    assign PCp4      = pcp4Q;
`endif

    // Next-state FIFO bookkeeping and the next registered head entry
    always_comb begin
        ackTaken      = imemAck && (reqState == BUSY);
        pushPc        = imemAddr + 32'd4;
        pop           = insValidQ && insReady && !redirect;
        push          = ackTaken && !redirect && !(bypassHit && insReady);
        countAfterPop = count - {{PW{1'b0}}, pop};
        countNext     = redirect ? '0 : countAfterPop + {{PW{1'b0}}, push};
        rdPtrNext     = redirect ? '0 : rdPtr + PW'(pop);
        // A push into a queue that drains to empty becomes the head directly
        if (countAfterPop == '0) begin
            headIns = imemData;
            headPc  = pushPc;
        end else begin
            headIns = memIns[rdPtrNext];
            headPc  = memPc[rdPtrNext];
        end
    end

    // Request FSM: issue, hold until ack, squash on redirect; owns fetchPC
    always_ff @(posedge clk) begin
        if (INT) begin
            reqState <= IDLE;
            imemReq  <= 1'b0;
            imemAddr <= '0;
            fetchPC  <= {entryPoint[31:2], 2'b00};
        end else begin
            if (redirect) fetchPC <= {redirectPC[31:2], 2'b00};
            case (reqState)
                IDLE: begin
                    if (!redirect && (count < DEPTH_CNT)) begin
                        reqState <= BUSY;
                        imemReq  <= 1'b1;
                        imemAddr <= fetchPC;
                    end
                end
                BUSY: begin
                    if (imemAck) begin
                        reqState <= IDLE;
                        imemReq  <= 1'b0;
                        if (!redirect) fetchPC <= pushPc;
                    end else if (redirect) begin
                        reqState <= SQUASH;
                    end
                end
                SQUASH: begin
                    if (imemAck) begin
                        reqState <= IDLE;
                        imemReq  <= 1'b0;
                    end
                end
                default: begin
                    reqState <= IDLE;
                    imemReq  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (!INT && push) begin
            memIns[wrPtr] <= imemData;
            memPc[wrPtr]  <= pushPc;
        end
    end

    // FIFO pointers, occupancy and registered head outputs
    always_ff @(posedge clk) begin
        if (INT) begin
            count     <= '0;
            rdPtr     <= '0;
            wrPtr     <= '0;
            insValidQ <= 1'b0;
            insQ      <= '0;
            pcp4Q     <= '0;
        end else begin
            count     <= countNext;
            rdPtr     <= rdPtrNext;
            wrPtr     <= redirect ? '0 : wrPtr + PW'(push);
            insValidQ <= (countNext != '0);
            if (countNext != '0) begin
                insQ  <= headIns;
                pcp4Q <= headPc;
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with a word=address memory model.
module tb_if_prefetch_queue;

    logic        clk = 1'b0;
    logic        INT = 1'b1;
    logic [31:0] entryPoint = 32'h80;
    logic        redirect = 1'b0;
    logic [31:0] redirectPC = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck = 1'b0;
    logic [31:0] imemData = '0;
    logic        insValid;
    logic [31:0] ins;
    logic [31:0] PCp4;
    logic        insReady = 1'b0;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned memLat = 0;
    int unsigned reqAge = 0;
    int unsigned nAck = 0;
    logic [31:0] ackLog [64];

    if_prefetch_queue #(.DEPTH(4), .ENTRY_WIDTH(32)) dut (
        .clk(clk), .INT(INT), .entryPoint(entryPoint),
        .redirect(redirect), .redirectPC(redirectPC),
        .imemReq(imemReq), .imemAddr(imemAddr),
        .imemAck(imemAck), .imemData(imemData),
        .insValid(insValid), .ins(ins), .PCp4(PCp4), .insReady(insReady)
    );

    always #5 clk = ~clk;

    task checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: step past the edge, then let the memory model answer
    task tick();
        @(posedge clk);
        #1;
        if (imemReq) begin
            if (reqAge == memLat) begin
                imemAck  = 1'b1;
                imemData = imemAddr;
                reqAge   = 0;
                if (nAck < 64) ackLog[nAck] = imemAddr;
                nAck++;
            end else begin
                imemAck = 1'b0;
                reqAge++;
            end
        end else begin
            imemAck = 1'b0;
            reqAge  = 0;
        end
    endtask

    task doReset(input logic [31:0] entry);
        INT = 1'b1;
        entryPoint = entry;
        redirect = 1'b0;
        tick();
        tick();
        INT = 1'b0;
        nAck = 0;
    endtask

    initial begin
        // Reset, fetch and backpressure
        memLat = 0;
        insReady = 1'b0;
        doReset(32'h80);
        checkVal("rst_req", {31'b0, imemReq}, 32'd0);
        checkVal("rst_valid", {31'b0, insValid}, 32'd0);
        checkVal("rst_ins", ins, 32'h0);
        checkVal("rst_pcp4", PCp4, 32'h0);
        tick();
        checkVal("first_addr", imemAddr, 32'h80);
        tick();
        checkVal("first_valid", {31'b0, insValid}, 32'd1);
        checkVal("first_ins", ins, 32'h80);
        checkVal("first_pcp4", PCp4, 32'h84);
        for (int i = 0; i < 12; i++) tick();
        checkVal("full_acks", nAck, 32'd4);
        checkVal("full_addr1", ackLog[1], 32'h84);
        checkVal("full_addr2", ackLog[2], 32'h88);
        checkVal("full_addr3", ackLog[3], 32'h8C);
        checkVal("full_req", {31'b0, imemReq}, 32'd0);
        insReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checkVal("pop_valid", {31'b0, insValid}, 32'd1);
            checkVal("pop_ins", ins, 32'h80 + 32'(4 * k));
            checkVal("pop_pcp4", PCp4, 32'h84 + 32'(4 * k));
            if (k < 4) tick();
        end
        checkVal("resume_addr", ackLog[4], 32'h90);

        // Redirect while a slow request is in flight
        memLat = 3;
        insReady = 1'b1;
        doReset(32'h80);
        for (int n = 0; n < 60 && !(imemReq && imemAddr == 32'h88 && !imemAck); n++) tick();
        checkVal("rd_wait88", {31'b0, imemReq && imemAddr == 32'h88}, 32'd1);
        redirect = 1'b1;
        redirectPC = 32'h200;
        tick();
        redirect = 1'b0;
        insReady = 1'b0;
        checkVal("rd_flush_valid", {31'b0, insValid}, 32'd0);
        checkVal("rd_hold_req", {31'b0, imemReq}, 32'd1);
        checkVal("rd_hold_addr", imemAddr, 32'h88);
        for (int n = 0; n < 60 && !insValid; n++) tick();
        checkVal("rd_ins", ins, 32'h200);
        checkVal("rd_pcp4", PCp4, 32'h204);
        checkVal("rd_log88", ackLog[2], 32'h88);
        checkVal("rd_log200", ackLog[3], 32'h200);

        // Redirect coinciding with ack, misaligned target
        memLat = 1;
        insReady = 1'b0;
        doReset(32'h80);
        for (int n = 0; n < 60 && !(imemReq && imemAck && imemAddr == 32'h84); n++) tick();
        checkVal("ra_wait84", {31'b0, imemAck && imemAddr == 32'h84}, 32'd1);
        redirect = 1'b1;
        redirectPC = 32'h203;
        tick();
        redirect = 1'b0;
        checkVal("ra_valid", {31'b0, insValid}, 32'd0);
        checkVal("ra_req", {31'b0, imemReq}, 32'd0);
        for (int n = 0; n < 60 && !imemReq; n++) tick();
        checkVal("ra_addr", imemAddr, 32'h200);
        for (int n = 0; n < 60 && !insValid; n++) tick();
        checkVal("ra_ins", ins, 32'h200);
        checkVal("ra_pcp4", PCp4, 32'h204);

        // Address wrap
        memLat = 0;
        insReady = 1'b0;
        doReset(32'hFFFFFFFC);
        for (int n = 0; n < 60 && !insValid; n++) tick();
        checkVal("wrap_ins", ins, 32'hFFFFFFFC);
        checkVal("wrap_pcp4", PCp4, 32'h0);
        for (int n = 0; n < 60 && !imemReq; n++) tick();
        checkVal("wrap_req", {31'b0, imemReq}, 32'd1);
        checkVal("wrap_addr", imemAddr, 32'h0);

        // Reset while pending with two entries queued, plus a late ack
        memLat = 5;
        insReady = 1'b0;
        doReset(32'h80);
        for (int n = 0; n < 80 && !(imemReq && imemAddr == 32'h88 && !imemAck); n++) tick();
        checkVal("int_pre_valid", {31'b0, insValid}, 32'd1);
        checkVal("int_pre_ins", ins, 32'h80);
        INT = 1'b1;
        entryPoint = 32'h300;
        imemAck = 1'b1;
        imemData = 32'hDEADBEEF;
        tick();
        imemAck = 1'b1;
        imemData = 32'hDEADBEEF;
        checkVal("int_valid", {31'b0, insValid}, 32'd0);
        checkVal("int_req", {31'b0, imemReq}, 32'd0);
        tick();
        INT = 1'b0;
        memLat = 0;
        tick();
        checkVal("int_restart_req", {31'b0, imemReq}, 32'd1);
        checkVal("int_restart_addr", imemAddr, 32'h300);
        tick();
        checkVal("int_restart_ins", ins, 32'h300);
        checkVal("int_restart_pcp4", PCp4, 32'h304);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
